// File: rtl/fir_filter_param.sv
// rtl/fir_filter_param.sv - parametrised direct-form FIR with runtime coefficients,
// 3-stage pipeline (multiply, sum/integrate, round/saturate) and optional integrator.
module fir_filter_param #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int TAPS      = 4,
  parameter int OUT_SHIFT = 8,
  parameter int ACC_W     = 24,
  parameter logic [TAPS*COEF_W-1:0] COEF_INIT = 32'h3C44443C,
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_clear,
  input  logic              i_mode,
  input  logic              i_coef_we,
  input  logic [AW-1:0]     i_coef_addr,
  input  logic [COEF_W-1:0] i_coef_wdata,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_ovf
);

  localparam int PW  = DATA_W + COEF_W;
  localparam int SW  = PW + $clog2(TAPS);
  localparam int AEW = ACC_W + 1;
  localparam logic [AEW-1:0] RND = (AEW'(1) << OUT_SHIFT) >> 1;

  logic [DATA_W-1:0] r_x      [TAPS];
  logic [COEF_W-1:0] r_coef   [TAPS];
  logic [COEF_W-1:0] r_coef_s [TAPS];
  logic [PW-1:0]     r_p      [TAPS];
  logic              r_v0, r_v1, r_v2;
  logic [ACC_W-1:0]  r_acc, r_res;
  logic              r_sat2;

  logic [SW-1:0]     w_sum;
  logic [AEW-1:0]    w_acc_ext;
  logic [ACC_W-1:0]  w_acc_next;
  logic [ACC_W-1:0]  w_res;
  logic              w_sat;
  logic [AEW-1:0]    w_t;
  logic              w_t_ovf;
  logic              w_addr_ok;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_sum = w_sum + SW'(r_p[k]);
    end
  end

  // Integrator clamps at all-ones instead of wrapping.
  assign w_acc_ext  = {1'b0, r_acc} + AEW'(w_sum);
  assign w_acc_next = w_acc_ext[ACC_W] ? '1 : w_acc_ext[ACC_W-1:0];
  assign w_res      = i_mode ? w_acc_next : ACC_W'(w_sum);
  assign w_sat      = i_mode & (&w_acc_next);

  assign w_t       = (AEW'(r_res) + RND) >> OUT_SHIFT;
  assign w_t_ovf   = |w_t[AEW-1:DATA_W];
  assign w_addr_ok = {1'b0, i_coef_addr} < (AW+1)'(TAPS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_coef[k] <= COEF_INIT[k*COEF_W +: COEF_W];
      end
    end else if (i_coef_we && w_addr_ok) begin
      r_coef[i_coef_addr] <= i_coef_wdata;
    end
  end

  // Coefficients are snapshotted with each accepted sample so a same-cycle
  // write only affects later samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k]      <= '0;
        r_coef_s[k] <= COEF_INIT[k*COEF_W +: COEF_W];
        r_p[k]      <= '0;
      end
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_acc       <= '0;
      r_res       <= '0;
      r_sat2      <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_ovf       <= 1'b0;
    end else if (i_clear) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
      end
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_acc       <= '0;
      o_out_valid <= 1'b0;
    end else begin
      r_v0 <= i_in_valid;
      if (i_in_valid) begin
        r_x[0] <= i_in_data;
        for (int k = 1; k < TAPS; k++) begin
          r_x[k] <= r_x[k-1];
        end
        for (int k = 0; k < TAPS; k++) begin
          r_coef_s[k] <= r_coef[k];
        end
      end

      r_v1 <= r_v0;
      if (r_v0) begin
        for (int k = 0; k < TAPS; k++) begin
          r_p[k] <= PW'(r_coef_s[k]) * PW'(r_x[k]);
        end
      end

      r_v2 <= r_v1;
      if (r_v1) begin
        r_res  <= w_res;
        r_sat2 <= w_sat;
        if (i_mode) begin
          r_acc <= w_acc_next;
        end
      end

      o_out_valid <= r_v2;
      if (r_v2) begin
        o_out_data <= w_t_ovf ? '1 : w_t[DATA_W-1:0];
        o_ovf      <= w_t_ovf | r_sat2;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_param.sv
// tb/tb_fir_filter_param.sv - directed bench for fir_filter_param with a
// sample-history reference model and literal-sequence checks.
module tb_fir_filter_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       clear = 1'b0;
  logic       mode = 1'b0;
  logic       coef_we = 1'b0;
  logic [1:0] coef_addr = 2'd0;
  logic [7:0] coef_wdata = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       ovf;

  fir_filter_param dut (
    .clk          (clk),
    .reset        (reset),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .i_clear      (clear),
    .i_mode       (mode),
    .i_coef_we    (coef_we),
    .i_coef_addr  (coef_addr),
    .i_coef_wdata (coef_wdata),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data),
    .o_ovf        (ovf)
  );

  always #5 clk = ~clk;

  localparam longint MAXA = (64'd1 << 24) - 1;

  typedef struct {longint s; int c;} tok_t;

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     hist[4] = '{0, 0, 0, 0};
  int     cm[4] = '{'h3C, 'h44, 'h44, 'h3C};
  longint acc_m = 0;
  tok_t   q[$];
  int     got_d[$];
  int     got_o[$];

  function automatic void chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  // Reference: every accepted sample yields one FIR sum from the coefficients
  // in force before that edge's write; tokens are lost on clear or reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist = '{0, 0, 0, 0};
      cm = '{'h3C, 'h44, 'h44, 'h3C};
      acc_m = 0;
      q.delete();
    end else begin
      cyc++;
      if (clear) begin
        hist = '{0, 0, 0, 0};
        acc_m = 0;
        q.delete();
      end else if (in_valid) begin
        longint s;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(in_data);
        s = 0;
        for (int k = 0; k < 4; k++) s += longint'(cm[k]) * longint'(hist[k]);
        q.push_back('{s: s, c: cyc});
      end
      if (coef_we) cm[coef_addr] = int'(coef_wdata);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].c + 3 < cyc) begin
        chk("missing_output", 0, 1);
        void'(q.pop_front());
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", longint'(out_valid), 0);
        end else begin
          tok_t   tk;
          longint r, t;
          bit     sat;
          tk = q.pop_front();
          sat = 1'b0;
          if (mode) begin
            acc_m = acc_m + tk.s;
            if (acc_m > MAXA) acc_m = MAXA;
            r = acc_m;
            sat = (acc_m == MAXA);
          end else begin
            r = tk.s;
          end
          t = (r + 128) >> 8;
          chk("latency", cyc - tk.c, 3);
          chk("out_data", longint'(out_data), (t > 255) ? 255 : t);
          chk("ovf", longint'(ovf), ((t > 255) || (mode && sat)) ? 1 : 0);
          got_d.push_back(int'(out_data));
          got_o.push_back(int'(ovf));
        end
      end
    end
  end

  task automatic drive(input bit v, input int d, input bit clr = 1'b0,
                       input bit we = 1'b0, input int a = 0, input int wd = 0);
    in_valid   = v;
    in_data    = 8'(d);
    clear      = clr;
    coef_we    = we;
    coef_addr  = 2'(a);
    coef_wdata = 8'(wd);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear    = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input string nm, input int n, input int e[8], input int eo[8]);
    chk({nm, "_count"}, got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      chk($sformatf("%s_data[%0d]", nm, i), got_d[i], e[i]);
      chk($sformatf("%s_ovf[%0d]", nm, i), got_o[i], eo[i]);
    end
    got_d.delete();
    got_o.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_out_data", longint'(out_data), 0);
    chk("reset_ovf", longint'(ovf), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Impulse
    drive(1, 'h80);
    repeat (5) drive(1, 0);
    drain();
    expect_seq("impulse", 6, '{'h1E, 'h22, 'h22, 'h1E, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

    // Step
    drive(0, 0, 1);
    repeat (6) drive(1, 'hFF);
    drain();
    expect_seq("step", 6, '{'h3C, 'h80, 'hC3, 'hFF, 'hFF, 'hFF, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

    // Saturate with c[0]=FF
    drive(0, 0, 1, 1, 0, 'hFF);
    repeat (5) drive(1, 'hFF);
    drain();
    expect_seq("saturate", 5, '{'hFE, 'hFF, 'hFF, 'hFF, 'hFF, 0, 0, 0}, '{0, 1, 1, 1, 1, 0, 0, 0});
    drive(0, 0, 1, 1, 0, 'h3C);

    // Integrator
    mode = 1'b1;
    repeat (6) drive(1, 1);
    drain();
    expect_seq("integrator", 6, '{0, 1, 2, 3, 4, 5, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    mode = 1'b0;
    drive(0, 0, 1);

    // Coefficient write in the same cycle as a sample
    drive(1, 'h80, 0, 1, 0, 0);
    drive(1, 0);
    drain();
    expect_seq("coef_same_cycle", 2, '{'h1E, 'h22, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    drive(0, 0, 1, 1, 0, 'h3C);

    // clear together with in_valid drops the sample
    drive(1, 'h80, 1);
    drive(1, 0);
    drain();
    expect_seq("clear_drop", 1, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

    // Gapped input
    drive(1, 'h80);
    drive(0, 0);
    drive(0, 0);
    drive(1, 0);
    drive(0, 0);
    drive(1, 0);
    drain();
    expect_seq("gapped", 3, '{'h1E, 'h22, 'h22, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

    // Reset mid-stream, then coefficients must be back at their initial values
    drive(0, 0, 1, 1, 0, 'hFF);
    drive(1, 'hFF);
    drive(1, 'hFF);
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", longint'(out_valid), 0);
    chk("midreset_out_data", longint'(out_data), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_d.delete();
    got_o.delete();
    @(posedge clk);
    #1;
    drive(1, 'h80);
    repeat (3) drive(1, 0);
    drain();
    expect_seq("after_reset", 4, '{'h1E, 'h22, 'h22, 'h1E, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
